// File: rtl/iq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : iq_pkg
// Purpose  : Shared types, constants and small helpers for the instruction
//            issue queue and any block that consumes its entries.
// Contents : iq_entry_t   - {pc, instr} entry layout (pc in the upper half)
//            IQ_ENTRY_W   - entry width in bits
//            iq_popcount  - number of set bits in a 32-bit vector
//            iq_min       - minimum of two unsigned values
// Revision : 1.0 - initial release
// ============================================================================
package iq_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } iq_entry_t;

    localparam int IQ_ENTRY_W = 64;

    function automatic int unsigned iq_popcount(input logic [31:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            n = n + {31'd0, v[i]};
        end
        return n;
    endfunction

    function automatic int unsigned iq_min(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_issue_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_queue_if
// Purpose  : Bundles the fetch-side push channel, the issue-side presentation
//            channel and the flush control of the instruction issue queue.
// Ports    : flush, push_valid, push_mask, push_data, issue_take  (to queue)
//            push_ready, issue_valid, issue_data, count, full      (from queue)
// Modports : master - fetch/issue/redirect side driving the queue
//            slave  - the queue itself
// Revision : 1.0 - initial release
// ============================================================================
interface instr_issue_queue_if
    import iq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = IQ_ENTRY_W
);
    localparam int TAKE_W = $clog2(ISSUE_W + 1);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic                         flush;
    logic                         push_valid;
    logic [FETCH_W-1:0]           push_mask;
    logic [FETCH_W*ENTRY_W-1:0]   push_data;
    logic                         push_ready;
    logic [ISSUE_W-1:0]           issue_valid;
    logic [ISSUE_W*ENTRY_W-1:0]   issue_data;
    logic [TAKE_W-1:0]            issue_take;
    logic [CNT_W-1:0]             count;
    logic                         full;

    modport master (
        output flush, push_valid, push_mask, push_data, issue_take,
        input  push_ready, issue_valid, issue_data, count, full
    );

    modport slave (
        input  flush, push_valid, push_mask, push_data, issue_take,
        output push_ready, issue_valid, issue_data, count, full
    );

endinterface
`default_nettype wire

// File: rtl/iq_compact.sv
`default_nettype none
// ============================================================================
// Module   : iq_compact
// Purpose  : Combinational lane compactor. Packs the lanes whose mask bit is
//            set into consecutive low lanes, preserving lane order, and
//            reports how many lanes are valid.
// Ports    : mask       in  LANES          per-lane valid, lane 0 = oldest
//            data       in  LANES*ENTRY_W  sparse lane data
//            dense_data out LANES*ENTRY_W  compacted lanes (unused lanes = 0)
//            n_valid    out CNT_W          popcount(mask)
// Revision : 1.0 - initial release
// ============================================================================
module iq_compact
    import iq_pkg::*;
#(
    parameter  int LANES   = 2,
    parameter  int ENTRY_W = IQ_ENTRY_W,
    localparam int CNT_W   = $clog2(LANES + 1)
) (
    input  wire logic [LANES-1:0]         mask,
    input  wire logic [LANES*ENTRY_W-1:0] data,
    output logic      [LANES*ENTRY_W-1:0] dense_data,
    output logic      [CNT_W-1:0]         n_valid
);

    always_comb begin
        int unsigned idx;
        dense_data = '0;
        idx        = 0;
        // Each set lane lands at the slot equal to the number of set lanes
        // below it, which keeps the original lane order.
        for (int unsigned i = 0; i < LANES; i++) begin
            if (mask[i]) begin
                dense_data[idx*ENTRY_W +: ENTRY_W] = data[i*ENTRY_W +: ENTRY_W];
                idx = idx + 1;
            end
        end
        n_valid = CNT_W'(iq_popcount(32'(mask)));
    end

endmodule
`default_nettype wire

// File: rtl/instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_issue_queue
// Purpose  : Multi-port circular instruction queue between fetch and issue.
//            Accepts up to FETCH_W mask-compacted entries per cycle, presents
//            the ISSUE_W oldest entries, and drains 0..ISSUE_W per cycle.
//            A synchronous flush empties the queue in one cycle.
// Ports    : clk    in   clock, rising edge
//            rst_n  in   asynchronous active-low reset
//            bus    slave modport of instr_issue_queue_if (push/issue/flush)
// Options  : IQ_BYPASS_EN - when defined, a push into an empty queue is
//            presented on issue_* in the same cycle and may be consumed at
//            once; otherwise entries become visible the cycle after push.
// Revision : 1.0 - initial release
// ============================================================================
module instr_issue_queue
    import iq_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8,
    parameter int ENTRY_W = IQ_ENTRY_W
) (
    input wire logic          clk,
    input wire logic          rst_n,
    instr_issue_queue_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int NP_W  = $clog2(FETCH_W + 1);

    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]           count_q,  count_d;
    logic [ENTRY_W-1:0]         mem_q [DEPTH];
    logic [ENTRY_W-1:0]         mem_d [DEPTH];

    logic [FETCH_W*ENTRY_W-1:0] w_dense;
    logic [NP_W-1:0]            w_n_push;
    logic                       w_push_ready;
    logic                       w_accept;
    logic                       w_bypass;
    int unsigned                w_count_i;
    int unsigned                w_n_push_i;
    int unsigned                w_n_pop_i;
    int unsigned                w_avail_i;
    int unsigned                w_skip_i;

    iq_compact #(
        .LANES   (FETCH_W),
        .ENTRY_W (ENTRY_W)
    ) u_compact (
        .mask       (bus.push_mask),
        .data       (bus.push_data),
        .dense_data (w_dense),
        .n_valid    (w_n_push)
    );

    // Credit is computed from registered occupancy only, so a pop in the same
    // cycle never opens room for a push.
    assign w_push_ready   = (DEPTH - int'(count_q)) >= FETCH_W;
    assign bus.push_ready = w_push_ready;
    assign bus.count      = count_q;
    assign bus.full       = (count_q == CNT_W'(DEPTH));

`ifdef IQ_BYPASS_EN
    localparam int LANES_MAX = (FETCH_W > ISSUE_W) ? FETCH_W : ISSUE_W;
    logic [LANES_MAX*ENTRY_W-1:0] w_dense_pad;

    always_comb begin
        w_dense_pad = '0;
        w_dense_pad[FETCH_W*ENTRY_W-1:0] = w_dense;
    end
`endif

    always_comb begin
        w_accept   = bus.push_valid && w_push_ready && !bus.flush;
        w_n_push_i = w_accept ? 32'(w_n_push) : 32'd0;
        w_count_i  = 32'(count_q);
        w_bypass   = 1'b0;
`ifdef IQ_BYPASS_EN
        w_bypass   = w_accept && (count_q == '0);
`endif
        // Entries available to issue this cycle: the fresh push lanes when
        // bypassing an empty queue, otherwise the stored occupancy.
        w_avail_i  = w_bypass ? w_n_push_i : w_count_i;
        w_n_pop_i  = iq_min(32'(bus.issue_take), w_avail_i);
        // Bypassed lanes that issue consumes right away never need a slot.
        w_skip_i   = w_bypass ? w_n_pop_i : 32'd0;

        bus.issue_valid = '0;
        bus.issue_data  = '0;
        for (int unsigned i = 0; i < ISSUE_W; i++) begin
            bus.issue_valid[i] = (i < w_count_i);
            bus.issue_data[i*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
`ifdef IQ_BYPASS_EN
        if (w_bypass) begin
            for (int unsigned i = 0; i < ISSUE_W; i++) begin
                bus.issue_valid[i] = (i < w_n_push_i);
                bus.issue_data[i*ENTRY_W +: ENTRY_W] = w_dense_pad[i*ENTRY_W +: ENTRY_W];
            end
        end
`endif

        mem_d = mem_q;
        for (int unsigned k = 0; k < FETCH_W; k++) begin
            if ((k < w_n_push_i) && (k >= w_skip_i)) begin
                mem_d[wr_ptr_q + PTR_W'(k)] = w_dense[k*ENTRY_W +: ENTRY_W];
            end
        end

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(w_n_pop_i);
            wr_ptr_d = wr_ptr_q + PTR_W'(w_n_push_i);
            count_d  = CNT_W'(w_count_i + w_n_push_i - w_n_pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Issue must never take more than is presented; the datapath clamps anyway.
    a_take_le_avail : assert property (
        @(posedge clk) disable iff (!rst_n)
        (bus.flush || (32'(bus.issue_take) <= w_avail_i))
    );

endmodule
`default_nettype wire

// File: tb/tb_instr_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_issue_queue
// Purpose  : Self-checking bench for instr_issue_queue (FETCH_W=2, ISSUE_W=2,
//            DEPTH=8). Directed vector table plus hand-written sequences for
//            same-cycle bypass and asynchronous reset.
// Options  : IQ_BYPASS_EN changes the expected same-cycle issue behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_issue_queue;
    import iq_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_issue_queue_if #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8), .ENTRY_W(64)) bus ();

    instr_issue_queue #(
        .FETCH_W (2),
        .ISSUE_W (2),
        .DEPTH   (8),
        .ENTRY_W (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic        pv;
        logic [1:0]  mask;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  take;
        logic        fl;
        int          e_cnt;
        logic [1:0]  e_valid;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [63:0] ent(input logic [31:0] pc);
        iq_entry_t e;
        e.pc    = pc;
        e.instr = pc ^ 32'h0050_0093;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic [1:0] mask, input logic [31:0] pc0,
                         input logic [31:0] pc1, input logic [1:0] take, input logic fl);
        bus.push_valid = pv;
        bus.push_mask  = mask;
        bus.push_data  = {ent(pc1), ent(pc0)};
        bus.issue_take = take;
        bus.flush      = fl;
    endtask

    task automatic chk_state(input string tag, input int cnt, input logic [1:0] valid,
                             input logic [31:0] pc0, input logic [31:0] pc1);
        chk({tag, ".count"}, 64'(bus.count), 64'(cnt));
        chk({tag, ".valid"}, 64'(bus.issue_valid), 64'(valid));
        chk({tag, ".full"},  64'(bus.full), 64'(cnt == 8));
        chk({tag, ".ready"}, 64'(bus.push_ready), 64'((8 - cnt) >= 2));
        if (valid[0]) chk({tag, ".lane0"}, bus.issue_data[63:0], ent(pc0));
        if (valid[1]) chk({tag, ".lane1"}, bus.issue_data[127:64], ent(pc1));
    endtask

    function automatic void add(input logic pv, input logic [1:0] mask, input logic [31:0] pc0,
                                input logic [31:0] pc1, input logic [1:0] take, input logic fl,
                                input int cnt, input logic [1:0] valid,
                                input logic [31:0] epc0, input logic [31:0] epc1);
        vec_t v;
        v.pv = pv; v.mask = mask; v.pc0 = pc0; v.pc1 = pc1; v.take = take; v.fl = fl;
        v.e_cnt = cnt; v.e_valid = valid; v.e_pc0 = epc0; v.e_pc1 = epc1;
        vecs.push_back(v);
    endfunction

    initial begin
        // Every push into an empty queue below uses take=0, so the bypass
        // option does not change any of these expectations.
        //   pv mask  pc0     pc1     take fl  cnt valid  lane0   lane1
        add(1, 2'b11, 32'h000, 32'h004, 0, 0, 2, 2'b11, 32'h000, 32'h004);
        add(1, 2'b11, 32'h008, 32'h00C, 0, 0, 4, 2'b11, 32'h000, 32'h004);
        add(1, 2'b11, 32'h010, 32'h014, 0, 0, 6, 2'b11, 32'h000, 32'h004);
        add(1, 2'b11, 32'h018, 32'h01C, 0, 0, 8, 2'b11, 32'h000, 32'h004);
        add(1, 2'b11, 32'h020, 32'h024, 0, 0, 8, 2'b11, 32'h000, 32'h004); // dropped
        add(0, 2'b00, 32'h000, 32'h000, 2, 0, 6, 2'b11, 32'h008, 32'h00C);
        add(0, 2'b00, 32'h000, 32'h000, 2, 0, 4, 2'b11, 32'h010, 32'h014);
        add(0, 2'b00, 32'h000, 32'h000, 2, 0, 2, 2'b11, 32'h018, 32'h01C);
        add(0, 2'b00, 32'h000, 32'h000, 2, 0, 0, 2'b00, 32'h000, 32'h000);
        add(1, 2'b10, 32'hFFC, 32'h014, 0, 0, 1, 2'b01, 32'h014, 32'h000); // compaction
        add(0, 2'b00, 32'h000, 32'h000, 1, 0, 0, 2'b00, 32'h000, 32'h000);
        add(1, 2'b11, 32'h100, 32'h104, 0, 0, 2, 2'b11, 32'h100, 32'h104);
        add(1, 2'b11, 32'h108, 32'h10C, 0, 0, 4, 2'b11, 32'h100, 32'h104);
        add(1, 2'b11, 32'h110, 32'h114, 0, 0, 6, 2'b11, 32'h100, 32'h104);
        add(1, 2'b11, 32'h118, 32'h11C, 2, 0, 6, 2'b11, 32'h108, 32'h10C); // writes 7,0
        add(1, 2'b11, 32'h120, 32'h124, 2, 0, 6, 2'b11, 32'h110, 32'h114);
        add(1, 2'b11, 32'h128, 32'h12C, 2, 0, 6, 2'b11, 32'h118, 32'h11C); // reads 7,0
        add(0, 2'b00, 32'h000, 32'h000, 2, 0, 4, 2'b11, 32'h120, 32'h124);
        add(0, 2'b00, 32'h000, 32'h000, 1, 0, 3, 2'b11, 32'h124, 32'h128);
        add(1, 2'b11, 32'h130, 32'h134, 0, 0, 5, 2'b11, 32'h124, 32'h128);
        add(1, 2'b11, 32'h200, 32'h204, 2, 1, 0, 2'b00, 32'h000, 32'h000); // flush
        add(1, 2'b11, 32'h300, 32'h304, 0, 0, 2, 2'b11, 32'h300, 32'h304);
        add(1, 2'b00, 32'h000, 32'h000, 0, 0, 2, 2'b11, 32'h300, 32'h304); // empty mask
        add(1, 2'b01, 32'h308, 32'hEEE, 1, 0, 2, 2'b11, 32'h304, 32'h308); // push+pop

        rst_n = 1'b0;
        drive(0, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 0, 2'b00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            @(negedge clk);
            drive(vecs[n].pv, vecs[n].mask, vecs[n].pc0, vecs[n].pc1, vecs[n].take, vecs[n].fl);
            @(posedge clk);
            #1;
            chk_state($sformatf("vec%0d", n), vecs[n].e_cnt, vecs[n].e_valid,
                      vecs[n].e_pc0, vecs[n].e_pc1);
        end

        // Drain to empty before the same-cycle issue check.
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 2, 0);
        @(posedge clk);
        #1;
        chk_state("drain", 0, 2'b00, 0, 0);

        @(negedge clk);
`ifdef IQ_BYPASS_EN
        drive(1, 2'b11, 32'h400, 32'h404, 1, 0);
        #1;
        chk("byp.same_valid", 64'(bus.issue_valid), 64'(2'b11));
        chk("byp.same_lane0", bus.issue_data[63:0], ent(32'h400));
        @(posedge clk);
        #1;
        chk_state("byp.next", 1, 2'b01, 32'h404, 0);
`else
        drive(1, 2'b11, 32'h400, 32'h404, 0, 0);
        #1;
        chk("byp.same_valid", 64'(bus.issue_valid), 64'(2'b00));
        @(posedge clk);
        #1;
        chk_state("byp.next", 2, 2'b11, 32'h400, 32'h404);
`endif

        // Asynchronous reset between clock edges clears state at once.
        @(negedge clk);
        drive(0, 2'b00, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_state("async_rst", 0, 2'b00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_state("post_rst", 0, 2'b00, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_issue_queue.md
Name: instr_issue_queue

Overview:
Parametrised multi-port instruction queue between the fetch cache controller and the scheduler/issue stage. Each cycle it accepts up to FETCH_W {instr, pc} entries from fetch, compacted by a lane mask. Each cycle it presents up to ISSUE_W oldest entries to issue, which may consume 0..ISSUE_W of them. This generalises the fixed 2-entry-per-push FIFO to configurable fetch width, issue width and depth, and adds partial pushes, partial pops and a single-cycle flush for jump redirect.

Parameters:
FETCH_W, 2, entries offered per push cycle
ISSUE_W, 2, entries presented per cycle to issue
DEPTH, 8, queue entries; power of 2, DEPTH >= max(FETCH_W, ISSUE_W)
ENTRY_W, 64, bits per entry: {pc[63:32], instr[31:0]}

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  discard all contents (jump accepted)
push_valid  in  1  fetch offers entries this cycle
push_mask  in  FETCH_W  per-lane valid; lane 0 = oldest
push_data  in  FETCH_W*ENTRY_W  lane i at bits [i*ENTRY_W +: ENTRY_W]
push_ready  out  1  free slots >= FETCH_W
issue_valid  out  ISSUE_W  thermometer: lane i valid iff i < occupancy
issue_data  out  ISSUE_W*ENTRY_W  lane i = i-th oldest entry
issue_take  in  $clog2(ISSUE_W+1)  entries consumed this cycle, oldest first
count  out  $clog2(DEPTH+1)  current occupancy
full  out  1  count == DEPTH

Behaviour:
- Reset (async, rst_n=0): rd_ptr=0, wr_ptr=0, count=0; outputs push_ready=1, issue_valid=0, full=0, count=0. Storage is not reset. issue_data is don't-care while its lane is invalid.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Slot index = (ptr + i) mod DEPTH.
- push_ready = (DEPTH - count) >= FETCH_W. It uses registered count only; a same-cycle pop gives no credit.
- Push accepted when push_valid && push_ready && !flush.
  - n_push = popcount(push_mask).
  - Set lanes are compacted in lane order and written to wr_ptr, wr_ptr+1, ...
  - wr_ptr += n_push.
  - push_mask == 0 is a legal no-op.
- Pop: n_pop = min(issue_take, count). rd_ptr += n_pop. issue_take > count is a protocol error; the SVA fires and the RTL clamps.
- count_next = count + n_push - n_pop. Simultaneous push and pop are both applied in the same cycle.
- Latency without bypass: a pushed entry is visible on issue_* the cycle after acceptance.
- Flush (synchronous): next cycle rd_ptr = wr_ptr = 0 and count = 0. Any same-cycle push and pop are ignored. Flush has priority over everything except reset.
- Reset asserted mid-operation clears immediately, regardless of clk.
- Full boundary: at count == DEPTH, push_ready = 0 and issue_take still drains. Empty boundary: at count == 0, issue_valid = 0 and issue_take is clamped to 0.

Optional Feature:
Macro IQ_BYPASS_EN.
- Defined: when count == 0 and a push is accepted, the compacted push lanes drive issue_valid/issue_data combinationally in the same cycle, so issue_take may consume them (zero-latency).
  - Only entries not taken are written.
  - wr_ptr advances by n_push, rd_ptr by n_pop.
  - Flush still suppresses the bypass.
- Undefined: the 1-cycle latency holds, and issue outputs depend only on registered state.

Decomposition:
- Package iq_pkg:
  - typedef iq_entry_t {logic [31:0] pc; logic [31:0] instr;}
  - localparam IQ_ENTRY_W = 64
  - popcount and min helper functions
- One natural sub-module: iq_compact. It is combinational and maps push_mask/push_data to dense lanes plus n_push. It is instantiated once and reusable by the scheduler.
- Storage is a flop array; no SRAM macro.

Test Plan (FETCH_W=2, ISSUE_W=2, DEPTH=8):
- Reset then push mask=2'b11 with {pc0=0x00,instr0=0x00500093},{pc1=0x04,instr1=0x00A00113} -> next cycle count=2, issue_valid=2'b11, lane0 pc=0x00, lane1 pc=0x04.
- Push 4 times with mask 2'b11 and no take -> count=8, full=1, push_ready=0. A 5th push is dropped and contents are unchanged. Take 2 -> count=6, push_ready=1.
- Push mask=2'b10 (pc=0x14 only) -> stored compacted. Next cycle lane0 pc=0x14, issue_valid=2'b01, count=1.
- Wrap: fill 6, take 2 for 3 cycles while pushing 2 per cycle -> order preserved across index 7->0; pcs emerge strictly ascending.
- Flush while count=5 with simultaneous push and issue_take=2 -> next cycle count=0, issue_valid=0, pointers 0. The pushed entries never appear.
- IQ_BYPASS_EN defined: empty queue, push 2'b11, issue_take=1 in the same cycle -> lane0 consumed the same cycle; next cycle count=1, lane0 = pushed lane1. Undefined: the same-cycle issue_valid=0.
